// File: rtl/y86_bus_pkg.sv
// Shared constants and the byte-lane helper for the y86 bus memory subsystem.
package y86_bus_pkg;

    localparam logic [2:0] CONSOLE_DATA_OFS = 3'd0;
    localparam logic [2:0] CONSOLE_STAT_OFS = 3'd4;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef logic [3:0][31:0] lanes_t;

    // Four consecutive byte indices starting at addr, each wrapped by mask.
    function automatic lanes_t byte_lanes(input logic [31:0] addr, input logic [31:0] mask);
        lanes_t lanes;
        for (int i = 0; i < 4; i++) begin
            lanes[i] = (addr + 32'(i)) & mask;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/y86_con_fifo.sv
// Console byte FIFO with a registered head output; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module y86_con_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  data_in,
    input  logic          pop,
    output logic [W-1:0]  data_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [W-1:0]  head_r;

    logic          pop_s;
    logic          push_s;
    logic [PW-1:0] rd_next_s;
    logic [CW-1:0] count_next_s;
    logic [W-1:0]  head_next_s;

    // Accept/advance decisions and the head value visible after this edge.
    always_comb begin
        pop_s        = pop && (count_r != {CW{1'b0}});
        push_s       = push && ((count_r != CW'(DEPTH)) || pop_s);
        rd_next_s    = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {W{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = data_in;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array; not reset, stale entries are never exposed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {W{1'b0}};
        end else begin
            rd_ptr_r <= rd_next_s;
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
        end
    end

    assign data_out = head_r;
    assign count    = count_r;
    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == {CW{1'b0}});

endmodule

// File: rtl/y86_bus_mem.sv
// Byte-addressed little-endian RAM slave for the y86 core with optional
// memory-mapped console TX FIFO (enabled by defining Y86_CONSOLE_EN).
module y86_bus_mem
    import y86_bus_pkg::*;
#(
    parameter int          MEM_BYTES    = 4096,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] CONSOLE_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_A,
    input  logic [31:0] bus_out,
    input  logic        bus_WE,
    input  logic        bus_RE,
    output logic [31:0] bus_in,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        err,
    output logic        ovf
);

    localparam int          AW       = $clog2(MEM_BYTES);
    localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);
    localparam logic [31:0] MEM_MASK = MEM_SIZE - 32'd1;

    logic [7:0]  mem_r [MEM_BYTES];
    lanes_t      lane_s;
    logic [31:0] ram_rd_s;
    logic [31:0] stat_s;
    logic        in_con_s;
    logic        out_of_range_s;
    logic        stat_wr_s;
    logic        err_r;

    assign lane_s   = byte_lanes(bus_A, MEM_MASK);
    assign ram_rd_s = {mem_r[lane_s[3][AW-1:0]], mem_r[lane_s[2][AW-1:0]],
                       mem_r[lane_s[1][AW-1:0]], mem_r[lane_s[0][AW-1:0]]};

`ifdef Y86_CONSOLE_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ofs_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic          ovf_r;

    // Subtraction wraps addresses below the base to huge offsets.
    assign ofs_s     = bus_A - CONSOLE_BASE;
    assign in_con_s  = (ofs_s < 32'd8);
    assign push_s    = bus_WE && in_con_s && (ofs_s[2:0] == CONSOLE_DATA_OFS);
    assign stat_wr_s = bus_WE && in_con_s && (ofs_s[2:0] == CONSOLE_STAT_OFS);
    assign pop_s     = con_valid && con_ready;
    assign con_valid = !empty_s;
    assign ovf       = ovf_r;

    y86_con_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .data_in  (bus_out[7:0]),
        .pop      (pop_s),
        .data_out (con_data),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Status word assembled from FIFO state.
    always_comb begin
        stat_s                         = 32'd0;
        stat_s[STAT_EMPTY]             = empty_s;
        stat_s[STAT_FULL]              = full_s;
        stat_s[STAT_OVF]               = ovf_r;
        stat_s[STAT_COUNT_LSB +: 8]    = 8'(count_s);
    end

    // Sticky overflow: set by a dropped push, cleared by a STATUS write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (stat_wr_s) begin
            ovf_r <= 1'b0;
        end else if (push_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`else
    logic unused_s;

    assign unused_s  = &{1'b0, con_ready, CONSOLE_BASE, 32'(FIFO_DEPTH)};
    assign in_con_s  = 1'b0;
    assign stat_wr_s = 1'b0;
    assign stat_s    = 32'd0;
    assign con_valid = 1'b0;
    assign con_data  = 8'd0;
    assign ovf       = 1'b0;
`endif

    assign out_of_range_s = (bus_A >= MEM_SIZE) && !in_con_s;

    // Combinational read path: the core samples in the same cycle.
    always_comb begin
        if (!bus_RE) begin
            bus_in = 32'd0;
        end else if (in_con_s) begin
            bus_in = (bus_A[2:0] - CONSOLE_BASE[2:0] == CONSOLE_STAT_OFS) ? stat_s : 32'd0;
        end else begin
            bus_in = ram_rd_s;
        end
    end

    // RAM byte writes, little-endian with index wrap; contents not reset.
    always_ff @(posedge clk) begin
        if (bus_WE && !in_con_s) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[lane_s[i][AW-1:0]] <= bus_out[8*i +: 8];
            end
        end
    end

    // Sticky out-of-range flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (stat_wr_s) begin
            err_r <= 1'b0;
        end else if ((bus_RE || bus_WE) && out_of_range_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

endmodule

// File: tb/tb_y86_bus_mem.sv
// Self-checking bench for y86_bus_mem; console tests run when Y86_CONSOLE_EN is defined.
module tb_y86_bus_mem;

    localparam logic [31:0] CB = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_A = 32'd0;
    logic [31:0] bus_out = 32'd0;
    logic        bus_WE = 1'b0;
    logic        bus_RE = 1'b0;
    logic [31:0] bus_in;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic        err;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  con_q[$];

    y86_bus_mem #(
        .MEM_BYTES    (4096),
        .FIFO_DEPTH   (8),
        .CONSOLE_BASE (CB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_A     (bus_A),
        .bus_out   (bus_out),
        .bus_WE    (bus_WE),
        .bus_RE    (bus_RE),
        .bus_in    (bus_in),
        .con_data  (con_data),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Advance one clock; any byte the sink takes at this edge is scoreboarded.
    task automatic step();
        #3;
        if (con_valid && con_ready) begin
            if (con_q.size() == 0) begin
                check_eq("con_unexpected", {24'd0, con_data}, 32'hFFFF_FFFF);
            end else begin
                check_eq("con_data", {24'd0, con_data}, {24'd0, con_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_A   = a;
        bus_out = d;
        bus_WE  = 1'b1;
        bus_RE  = 1'b0;
        step();
        bus_WE  = 1'b0;
    endtask

    task automatic con_push(input logic [7:0] b, input bit accepted);
        if (accepted) con_q.push_back(b);
        wr(CB, {24'd0, b});
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_A  = a;
        bus_RE = 1'b1;
        rd_q.push_back(exp);
        #1;
        check_eq(tag, bus_in, rd_q.pop_front());
        step();
        bus_RE = 1'b0;
    endtask

    task automatic drain();
        con_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (con_q.size() == 0 && !con_valid) break;
            step();
        end
        check_eq("drain_left", con_q.size(), 32'd0);
        check_eq("drain_valid", {31'd0, con_valid}, 32'd0);
    endtask

    initial begin
        #1;
        check_eq("rst_valid", {31'd0, con_valid}, 32'd0);
        check_eq("rst_data", {24'd0, con_data}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        wr(32'h10, 32'h1122_3344);
        wr(32'h14, 32'h5566_7788);
        rd("rd_aligned", 32'h10, 32'h1122_3344);
        rd("rd_unaligned", 32'h11, 32'h8811_2233);

        bus_A  = 32'h10;
        bus_RE = 1'b0;
        #1;
        check_eq("re_low", bus_in, 32'd0);
        step();

        wr(32'h0, 32'h0302_0100);
        wr(32'hFFE, 32'hAABB_CCDD);
        rd("rd_wrap", 32'hFFE, 32'hAABB_CCDD);
        rd("rd_wrap_fff", 32'hFFF, 32'h02AA_BBCC);
        rd("rd_low", 32'h0, 32'h0302_AABB);
        check_eq("wrap_err", {31'd0, err}, 32'd0);

        rd("rd_oor", 32'h2000, 32'h0302_AABB);
        check_eq("oor_err", {31'd0, err}, 32'd1);

`ifdef Y86_CONSOLE_EN
        wr(CB + 32'd4, 32'hFFFF_FFFF);
        check_eq("err_clear", {31'd0, err}, 32'd0);
        rd("stat_empty", CB + 32'd4, 32'h0000_0001);
        rd("con_data_reg", CB, 32'd0);

        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            con_push(8'h41 + 8'(i), i < 8);
        end
        rd("stat_full_ovf", CB + 32'd4, 32'h0000_0806);
        check_eq("ovf_set", {31'd0, ovf}, 32'd1);
        wr(CB + 32'd4, 32'd0);
        rd("stat_ovf_clr", CB + 32'd4, 32'h0000_0802);
        check_eq("head_stable", {24'd0, con_data}, 32'h41);
        drain();

        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            con_push(8'h50 + 8'(i), 1'b1);
        end
        con_ready = 1'b1;
        con_push(8'h5A, 1'b1);
        con_ready = 1'b0;
        rd("stat_push_pop", CB + 32'd4, 32'h0000_0802);
        check_eq("ovf_push_pop", {31'd0, ovf}, 32'd0);
        drain();

        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            con_push(8'h60 + 8'(i), 1'b1);
        end
        rd("rd_oor2", 32'h3000, 32'h0302_AABB);
`else
        wr(CB, 32'hCAFE_F00D);
        check_eq("nocon_err", {31'd0, err}, 32'd1);
        rd("nocon_ram", CB, 32'hCAFE_F00D);
        rd("nocon_stat", CB + 32'd4, 32'h0000_0000 | {8'd0, 24'd0});
        check_eq("nocon_valid", {31'd0, con_valid}, 32'd0);
        check_eq("nocon_ovf", {31'd0, ovf}, 32'd0);
`endif

        bus_A  = 32'h4000;
        bus_RE = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, con_valid}, 32'd0);
        check_eq("mid_rst_err", {31'd0, err}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        bus_RE = 1'b0;
        con_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
`ifdef Y86_CONSOLE_EN
        rd("stat_after_rst", CB + 32'd4, 32'h0000_0001);
`else
        rd("ram_after_rst", 32'h10, 32'h1122_3344);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
